// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a scanned, multiplexed active-low 7-segment display
// and presents each complete 4-digit frame through a valid/ready output register.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG_EN,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [15:0] VALUE,
  output logic [3:0]  DIGIT_OK,
  output logic        OVERRUN
);

  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'h40: seg_dec = {1'b1, 4'h0};
      7'h79: seg_dec = {1'b1, 4'h1};
      7'h24: seg_dec = {1'b1, 4'h2};
      7'h30: seg_dec = {1'b1, 4'h3};
      7'h19: seg_dec = {1'b1, 4'h4};
      7'h12: seg_dec = {1'b1, 4'h5};
      7'h02: seg_dec = {1'b1, 4'h6};
      7'h78: seg_dec = {1'b1, 4'h7};
      7'h00: seg_dec = {1'b1, 4'h8};
      7'h10: seg_dec = {1'b1, 4'h9};
      7'h08: seg_dec = {1'b1, 4'hA};
      7'h03: seg_dec = {1'b1, 4'hB};
      7'h46: seg_dec = {1'b1, 4'hC};
      7'h21: seg_dec = {1'b1, 4'hD};
      7'h06: seg_dec = {1'b1, 4'hE};
      7'h0E: seg_dec = {1'b1, 4'hF};
      default: seg_dec = 5'h00;
    endcase
  endfunction

  logic [10:0]      s1_q, s2_q, prev_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             fired_q, fired_d;
  logic [3:0]       mask_q, mask_d, mask_nxt;
  logic [3:0][3:0]  sh_val_q, sh_val_d;
  logic [3:0]       sh_ok_q, sh_ok_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       dok_q, dok_d;
  logic             diff, onehot, cap, complete, accept, load;
  logic [3:0]       en_s;
  logic [4:0]       dec;

  // prev_q is the sample the run counter describes, so capture decodes it
  assign diff     = (s2_q != prev_q);
  assign en_s     = prev_q[10:7];
  assign onehot   = (en_s != 4'b0000) && ((en_s & (en_s - 4'd1)) == 4'b0000);
  assign dec      = seg_dec(prev_q[6:0]);
  assign cap      = (cnt_q == 8'(STABLE_CYCLES)) && !fired_q && onehot;
  assign mask_nxt = mask_q | (cap ? en_s : 4'b0000);
  assign complete = (mask_nxt == 4'b1111);
  assign accept   = valid_q && OUT_READY;
  assign load     = complete && (!valid_q || OUT_READY);

  for (genvar n = 0; n < 4; n++) begin : g_slot
    assign sh_val_d[n] = (cap && en_s[n]) ? dec[3:0] : sh_val_q[n];
    assign sh_ok_d[n]  = (cap && en_s[n]) ? dec[4]   : sh_ok_q[n];
  end

  always_comb begin
    cnt_d   = diff ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
    // fired_q blocks a second capture while a saturated counter sits at 255
    fired_d = diff ? 1'b0 : (fired_q || (cnt_q == 8'(STABLE_CYCLES)));
    mask_d  = complete ? 4'b0000 : mask_nxt;
    valid_d = valid_q;
    value_d = value_q;
    dok_d   = dok_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      value_d = sh_val_d;
      dok_d   = sh_ok_d;
    end else if (complete) begin
      ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      cnt_q    <= 8'd1;
      fired_q  <= 1'b0;
      mask_q   <= '0;
      sh_val_q <= '0;
      sh_ok_q  <= '0;
      valid_q  <= 1'b0;
      value_q  <= '0;
      dok_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= {DIG_EN, SEG};
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      cnt_q    <= cnt_d;
      fired_q  <= fired_d;
      mask_q   <= mask_d;
      sh_val_q <= sh_val_d;
      sh_ok_q  <= sh_ok_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      dok_q    <= dok_d;
      ovr_q    <= ovr_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign VALUE     = value_q;
  assign DIGIT_OK  = dok_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-frame scans plus
// hand-written sequences for dwell, overrun, multi-hot and reset corners.
module tb_seg_scan_decoder;
  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic [6:0]  SEG;
  logic [3:0]  DIG_EN;
  logic        OUT_READY;
  logic        OUT_VALID;
  logic [15:0] VALUE;
  logic [3:0]  DIGIT_OK;
  logic        OVERRUN;

  int errors = 0;
  int checks = 0;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SEG(SEG), .DIG_EN(DIG_EN),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .VALUE(VALUE),
    .DIGIT_OK(DIGIT_OK), .OVERRUN(OVERRUN)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0][6:0] seg;
    logic [15:0]     exp_value;
    logic [3:0]      exp_ok;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one pattern for n rising edges; returns 1 ns after the last edge.
  task automatic hold(input logic [3:0] en, input logic [6:0] s, input int n);
    DIG_EN = en;
    SEG    = s;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic scan(input logic [3:0][6:0] segs, input int n);
    for (int d = 0; d < 4; d++) hold(4'b0001 << d, segs[d], n);
  endtask

  task automatic ack();
    OUT_READY = 1'b1;
    @(posedge CLOCK_50);
    #1;
    OUT_READY = 1'b0;
  endtask

  logic [3:0][6:0] f0, fe;

  initial begin
    vecs[0] = '{seg: {7'h30, 7'h24, 7'h79, 7'h40}, exp_value: 16'h3210, exp_ok: 4'b1111};
    vecs[1] = '{seg: {7'h0E, 7'h0E, 7'h7F, 7'h0E}, exp_value: 16'hFF0F, exp_ok: 4'b1101};
    vecs[2] = '{seg: {7'h00, 7'h78, 7'h02, 7'h12}, exp_value: 16'h8765, exp_ok: 4'b1111};
    vecs[3] = '{seg: {7'h46, 7'h03, 7'h08, 7'h10}, exp_value: 16'hCBA9, exp_ok: 4'b1111};
    vecs[4] = '{seg: {7'h00, 7'h7F, 7'h06, 7'h21}, exp_value: 16'h80ED, exp_ok: 4'b1011};
    f0 = {7'h30, 7'h24, 7'h79, 7'h40};
    fe = {7'h0E, 7'h0E, 7'h0E, 7'h0E};

    RESET_N = 1'b0; SEG = 7'h7F; DIG_EN = 4'b0000; OUT_READY = 1'b0;
    #25;
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_value", 32'(VALUE), 0);
    chk("rst_ok", 32'(DIGIT_OK), 0);
    chk("rst_ovr", 32'(OVERRUN), 0);
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    hold(4'b0000, 7'h7F, 4);

    for (int i = 0; i < 5; i++) begin
      ack();
      scan(vecs[i].seg, 8);
      chk($sformatf("vec%0d_valid", i), 32'(OUT_VALID), 1);
      chk($sformatf("vec%0d_value", i), 32'(VALUE), 32'(vecs[i].exp_value));
      chk($sformatf("vec%0d_ok", i), 32'(DIGIT_OK), 32'(vecs[i].exp_ok));
      chk($sformatf("vec%0d_ovr", i), 32'(OVERRUN), 0);
    end

    // Latency: last digit applied before edge t, OUT_VALID set at edge t+6
    ack();
    chk("lat_cleared", 32'(OUT_VALID), 0);
    for (int d = 0; d < 3; d++) hold(4'b0001 << d, f0[d], 8);
    hold(4'b1000, 7'h30, 6);
    chk("lat_early", 32'(OUT_VALID), 0);
    hold(4'b1000, 7'h30, 1);
    chk("lat_rise", 32'(OUT_VALID), 1);
    chk("lat_value", 32'(VALUE), 32'h3210);

    // Short 3-cycle dwell on digit 2 must not capture
    ack();
    hold(4'b0001, 7'h40, 8);
    hold(4'b0010, 7'h79, 8);
    hold(4'b0100, 7'h24, 3);
    hold(4'b1000, 7'h30, 8);
    hold(4'b0001, 7'h40, 8);
    chk("short_novalid", 32'(OUT_VALID), 0);
    hold(4'b0100, 7'h19, 8);
    chk("short_valid", 32'(OUT_VALID), 1);
    chk("short_value", 32'(VALUE), 32'h3410);

    // Second frame while not accepted is dropped
    ack();
    scan(f0, 8);
    chk("ovr_first", 32'(OUT_VALID), 1);
    scan(fe, 8);
    chk("ovr_keep_valid", 32'(OUT_VALID), 1);
    chk("ovr_keep_value", 32'(VALUE), 32'h3210);
    chk("ovr_flag", 32'(OVERRUN), 1);
    ack();
    chk("ovr_ack_valid", 32'(OUT_VALID), 0);
    chk("ovr_ack_flag", 32'(OVERRUN), 0);

    // Multi-hot enable must not fill the missing slot
    hold(4'b0001, 7'h40, 8);
    hold(4'b0010, 7'h79, 8);
    hold(4'b1000, 7'h30, 8);
    hold(4'b0110, 7'h24, 10);
    chk("mhot_novalid", 32'(OUT_VALID), 0);
    hold(4'b0100, 7'h24, 8);
    chk("mhot_valid", 32'(OUT_VALID), 1);
    chk("mhot_value", 32'(VALUE), 32'h3210);

    // Reset mid-frame discards partial captures
    ack();
    hold(4'b0001, 7'h19, 8);
    hold(4'b0010, 7'h19, 8);
    hold(4'b0100, 7'h19, 8);
    RESET_N = 1'b0;
    #5;
    chk("mid_rst_valid", 32'(OUT_VALID), 0);
    chk("mid_rst_value", 32'(VALUE), 0);
    chk("mid_rst_ok", 32'(DIGIT_OK), 0);
    chk("mid_rst_ovr", 32'(OVERRUN), 0);
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    hold(4'b1000, 7'h30, 8);
    chk("post_rst_partial", 32'(OUT_VALID), 0);
    hold(4'b0001, 7'h40, 8);
    hold(4'b0010, 7'h79, 8);
    chk("post_rst_partial2", 32'(OUT_VALID), 0);
    hold(4'b0100, 7'h24, 8);
    chk("post_rst_valid", 32'(OUT_VALID), 1);
    chk("post_rst_value", 32'(VALUE), 32'h3210);
    chk("post_rst_ok", 32'(DIGIT_OK), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
